ins_exec_muldiv: RTL

Multi-cycle RV32M/RV64M execute unit beside the single-cycle RV32I execute stage. It accepts one OP-opcode instruction with funct7=0000001 and runs an iterative multiply or restoring divide over XLEN/STEP_BITS cycles. The result is returned on the same register-write bundle the execute stage already drives, and `busy` stalls upstream issue while an instruction is in flight.

---
 rtl/ins_exec_muldiv_if.sv | 31 +++
 rtl/ins_exec_muldiv.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/ins_exec_muldiv_if.sv
// Decode-side request and register-write bundle for the multi-cycle M-extension unit.
// Master drives decode/operands/kill; slave returns busy, done and the register write.
interface ins_exec_muldiv_if #(
  parameter int XLEN = 32
);
  logic            op;
  logic            kill;
  logic [6:0]      ins_dec_op;
  logic [2:0]      ins_dec_funct3;
  logic [6:0]      ins_dec_funct7;
  logic [XLEN-1:0] reg_rs1_val;
  logic [XLEN-1:0] reg_rs2_val;
  logic [4:0]      reg_rd;
  logic            busy;
  logic            done;
  logic            reg_w_op;
  logic [4:0]      reg_w_reg_idx;
  logic [XLEN-1:0] reg_w_reg_val;

  modport master (
    output op, kill, ins_dec_op, ins_dec_funct3, ins_dec_funct7,
           reg_rs1_val, reg_rs2_val, reg_rd,
    input  busy, done, reg_w_op, reg_w_reg_idx, reg_w_reg_val
  );

  modport slave (
    input  op, kill, ins_dec_op, ins_dec_funct3, ins_dec_funct7,
           reg_rs1_val, reg_rs2_val, reg_rd,
    output busy, done, reg_w_op, reg_w_reg_idx, reg_w_reg_val
  );
endinterface

// File: rtl/ins_exec_muldiv.sv
// Iterative RV32M/RV64M multiply / restoring divide, STEP_BITS bits per cycle on negedge sys_clk.
// Latency XLEN/STEP_BITS+2 edges (1 for div-by-zero/overflow); busy stalls issue, no input queueing.
module ins_exec_muldiv #(
  parameter int XLEN      = 32,
  parameter int STEP_BITS = 1
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  ins_exec_muldiv_if.slave bus
);
  localparam int ITER = XLEN / STEP_BITS;
  localparam int CW   = $clog2(ITER + 1);

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

  state_t            r_state;
  logic              r_busy;
  logic              r_done;
  logic              r_w_op;
  logic [4:0]        r_w_idx;
  logic [XLEN-1:0]   r_w_val;
  logic [CW-1:0]     r_cnt;
  logic [2*XLEN-1:0] r_prod;
  logic [XLEN-1:0]   r_a;
  logic [2:0]        r_f3;
  logic [4:0]        r_rd;
  logic              r_neg;

  logic              w_acc;
  logic              w_sa;
  logic              w_sb;
  logic              w_neg;
  logic [XLEN-1:0]   w_m1;
  logic [XLEN-1:0]   w_m2;
  logic              w_dz;
  logic              w_ovf;
  logic [XLEN-1:0]   w_sval;
  logic [2*XLEN:0]   w_mp;
  logic [XLEN:0]     w_rem;
  logic [XLEN-1:0]   w_quo;
  logic [2*XLEN-1:0] w_pfix;
  logic [XLEN-1:0]   w_dsel;
  logic [XLEN-1:0]   w_res;

  // DONE counts as free so a held op issues on the DONE -> IDLE edge.
  assign w_acc = bus.op && (bus.ins_dec_op == 7'b0110011) && (bus.ins_dec_funct7 == 7'b0000001)
              && ((r_state == S_IDLE) || (r_state == S_DONE)) && !bus.kill;

  // rs1 is signed for MULH, MULHSU, DIV, REM; rs2 for MULH, DIV, REM.
  assign w_sa  = bus.reg_rs1_val[XLEN-1] &&
                 ((bus.ins_dec_funct3 == 3'b001) || (bus.ins_dec_funct3 == 3'b010) ||
                  (bus.ins_dec_funct3 == 3'b100) || (bus.ins_dec_funct3 == 3'b110));
  assign w_sb  = bus.reg_rs2_val[XLEN-1] &&
                 ((bus.ins_dec_funct3 == 3'b001) || (bus.ins_dec_funct3 == 3'b100) ||
                  (bus.ins_dec_funct3 == 3'b110));
  assign w_neg = (bus.ins_dec_funct3 == 3'b110) ? w_sa : (w_sa ^ w_sb);
  assign w_m1  = w_sa ? -bus.reg_rs1_val : bus.reg_rs1_val;
  assign w_m2  = w_sb ? -bus.reg_rs2_val : bus.reg_rs2_val;

  assign w_dz   = bus.ins_dec_funct3[2] && (bus.reg_rs2_val == '0);
  assign w_ovf  = bus.ins_dec_funct3[2] && !bus.ins_dec_funct3[0]
               && (bus.reg_rs1_val == {1'b1, {(XLEN-1){1'b0}}}) && (bus.reg_rs2_val == '1);
  assign w_sval = w_dz ? (bus.ins_dec_funct3[1] ? bus.reg_rs1_val : '1)
                       : (bus.ins_dec_funct3[1] ? '0 : bus.reg_rs1_val);

  // One cycle of shift-add and restoring-divide steps; multiplier/dividend live in r_prod low half.
  always_comb begin
    w_mp = {1'b0, r_prod};
    for (int k = 0; k < STEP_BITS; k++) begin
      if (w_mp[0]) w_mp[2*XLEN:XLEN] = w_mp[2*XLEN:XLEN] + {1'b0, r_a};
      w_mp = w_mp >> 1;
    end
    w_rem = {1'b0, r_prod[2*XLEN-1:XLEN]};
    w_quo = r_prod[XLEN-1:0];
    for (int k = 0; k < STEP_BITS; k++) begin
      w_rem = {w_rem[XLEN-1:0], w_quo[XLEN-1]};
      w_quo = {w_quo[XLEN-2:0], 1'b0};
      if (w_rem >= {1'b0, r_a}) begin
        w_rem    = w_rem - {1'b0, r_a};
        w_quo[0] = 1'b1;
      end
    end
  end

  always_comb begin
    w_pfix = r_neg ? -r_prod : r_prod;
    w_dsel = r_f3[1] ? r_prod[2*XLEN-1:XLEN] : r_prod[XLEN-1:0];
    if (!r_f3[2]) w_res = (r_f3[1:0] == 2'b00) ? w_pfix[XLEN-1:0] : w_pfix[2*XLEN-1:XLEN];
    else          w_res = r_neg ? -w_dsel : w_dsel;
  end

  always_ff @(negedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_w_op  <= 1'b0;
      r_w_idx <= '0;
      r_w_val <= '0;
      r_cnt   <= '0;
      r_prod  <= '0;
      r_a     <= '0;
      r_f3    <= '0;
      r_rd    <= '0;
      r_neg   <= 1'b0;
    end else begin
      r_done  <= 1'b0;
      r_w_op  <= 1'b0;
      r_w_idx <= '0;
      r_w_val <= '0;
      if (bus.kill) begin
        r_state <= S_IDLE;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE, S_DONE: begin
            if (w_acc) begin
              r_f3   <= bus.ins_dec_funct3;
              r_rd   <= bus.reg_rd;
              r_neg  <= w_neg;
              r_busy <= 1'b1;
              r_cnt  <= CW'(ITER);
              if (bus.ins_dec_funct3[2]) begin
                r_prod <= {{XLEN{1'b0}}, w_m1};
                r_a    <= w_m2;
              end else begin
                r_prod <= {{XLEN{1'b0}}, w_m2};
                r_a    <= w_m1;
              end
              if (w_dz || w_ovf) begin
                r_state <= S_DONE;
                r_done  <= 1'b1;
                r_w_op  <= |bus.reg_rd;
                r_w_idx <= bus.reg_rd;
                r_w_val <= w_sval;
              end else begin
                r_state <= bus.ins_dec_funct3[2] ? S_DIV : S_MUL;
              end
            end else begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end
          S_MUL: begin
            r_prod <= w_mp[2*XLEN-1:0];
            r_cnt  <= r_cnt - CW'(1);
            if (r_cnt == CW'(1)) r_state <= S_FIX;
          end
          S_DIV: begin
            r_prod <= {w_rem[XLEN-1:0], w_quo};
            r_cnt  <= r_cnt - CW'(1);
            if (r_cnt == CW'(1)) r_state <= S_FIX;
          end
          S_FIX: begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_w_op  <= |r_rd;
            r_w_idx <= r_rd;
            r_w_val <= w_res;
          end
          default: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.busy          = r_busy;
  assign bus.done          = r_done;
  assign bus.reg_w_op      = r_w_op;
  assign bus.reg_w_reg_idx = r_w_idx;
  assign bus.reg_w_reg_val = r_w_val;
endmodule
